// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the mem_arbiter block: FSM states,
// load/store size encodings and requester identifiers.
package mem_arbiter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_IF_RD,
        ST_LS_RD,
        ST_LS_WR,
        ST_RMW_RD,
        ST_RMW_WR
    } state_e;

    localparam logic [1:0] LS_SIZE_B = 2'd0;
    localparam logic [1:0] LS_SIZE_H = 2'd1;
    localparam logic [1:0] LS_SIZE_W = 2'd2;

    localparam logic REQ_IF = 1'b0;
    localparam logic REQ_LS = 1'b1;

    // Byte and half stores must be done as a read-modify-write pair.
    function automatic logic is_sub_word(input logic [1:0] size);
        return (size == LS_SIZE_B) || (size == LS_SIZE_H);
    endfunction

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-way round-robin arbiter between the fetch and load/store requesters.
// The grant is combinational; the last-granted requester is remembered on each grant.
module mem_arbiter_rr_arb2 (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_en,
    input  logic i_req_if,
    input  logic i_req_ls,
    output logic o_gnt_if,
    output logic o_gnt_ls
);
    import mem_arbiter_pkg::*;

    logic r_last;

    // On contention the requester that was not served last wins.
    always_comb begin
        o_gnt_if = 1'b0;
        o_gnt_ls = 1'b0;
        if (i_en) begin
            if (i_req_if && (!i_req_ls || (r_last == REQ_LS))) begin
                o_gnt_if = 1'b1;
            end else if (i_req_ls) begin
                o_gnt_ls = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_last <= REQ_LS;
        end else if (o_gnt_if) begin
            r_last <= REQ_IF;
        end else if (o_gnt_ls) begin
            r_last <= REQ_LS;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares a single-port byte-addressed Mem between instruction fetch and load/store,
// with RMW for sub-word stores. Optional macro MEM_ARB_BOUNDS_EN enables the ls bounds check.
module mem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MEM_SIZE   = 1024
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic                  if_ready,
    output logic                  if_rvalid,
    output logic [DATA_WIDTH-1:0] if_rdata,
    input  logic                  ls_req,
    input  logic                  ls_we,
    input  logic [1:0]            ls_size,
    input  logic                  ls_unsigned,
    input  logic [ADDR_WIDTH-1:0] ls_addr,
    input  logic [DATA_WIDTH-1:0] ls_wdata,
    output logic                  ls_ready,
    output logic                  ls_done,
    output logic [DATA_WIDTH-1:0] ls_rdata,
    output logic                  ls_err,
    output logic                  mem_op,
    output logic                  mem_rw,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_data_w,
    input  logic [DATA_WIDTH-1:0] mem_data_r
);
    import mem_arbiter_pkg::*;

    if ((DATA_WIDTH != 32) || (MEM_SIZE < 4)) begin : g_param_check
        $error("mem_arbiter: DATA_WIDTH must be 32 and MEM_SIZE at least 4");
    end

    state_e                r_state;
    state_e                w_next_state;
    logic                  w_gnt_if;
    logic                  w_gnt_ls;
    logic                  w_idle;
    logic                  w_oob;
    logic                  w_ls_sub;
    logic [DATA_WIDTH-1:0] w_load_ext;
    logic [DATA_WIDTH-1:0] w_merge;

    logic                  r_mem_op;
    logic                  r_mem_rw;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [DATA_WIDTH-1:0] r_mem_data_w;
    logic                  r_if_rvalid;
    logic [DATA_WIDTH-1:0] r_if_rdata;
    logic                  r_ls_done;
    logic [DATA_WIDTH-1:0] r_ls_rdata;
    logic [1:0]            r_ls_size;
    logic                  r_ls_unsigned;
    logic [15:0]           r_ls_wdata;
    logic                  r_oob;

    assign w_idle   = (r_state == ST_IDLE);
    assign w_ls_sub = is_sub_word(ls_size);

    mem_arbiter_rr_arb2 u_rr_arb2 (
        .i_clk    (sys_clk),
        .i_rst_n  (sys_rst),
        .i_en     (w_idle),
        .i_req_if (if_req),
        .i_req_ls (ls_req),
        .o_gnt_if (w_gnt_if),
        .o_gnt_ls (w_gnt_ls)
    );

    assign if_ready = w_gnt_if;
    assign ls_ready = w_gnt_ls;

`ifdef MEM_ARB_BOUNDS_EN
    localparam logic [ADDR_WIDTH-1:0] LP_LAST_WORD = ADDR_WIDTH'(MEM_SIZE - 4);

    logic r_ls_err;

    assign w_oob = (ls_addr > LP_LAST_WORD);

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            r_ls_err <= 1'b0;
        end else begin
            r_ls_err <= (r_state == ST_LS_RD) && r_oob;
        end
    end

    assign ls_err = r_ls_err;
`else
    assign w_oob  = 1'b0;
    assign ls_err = 1'b0;
`endif

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // A rejected (out-of-range) access reuses LS_RD as its one-cycle completion slot.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_gnt_if) begin
                    w_next_state = ST_IF_RD;
                end else if (w_gnt_ls) begin
                    if (w_oob || !ls_we) begin
                        w_next_state = ST_LS_RD;
                    end else if (w_ls_sub) begin
                        w_next_state = ST_RMW_RD;
                    end else begin
                        w_next_state = ST_LS_WR;
                    end
                end
            end
            ST_RMW_RD: w_next_state = ST_RMW_WR;
            ST_IF_RD, ST_LS_RD, ST_LS_WR, ST_RMW_WR: w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        w_load_ext = mem_data_r;
        w_merge    = mem_data_r;
        case (r_ls_size)
            LS_SIZE_B: begin
                w_load_ext = {{(DATA_WIDTH-8){mem_data_r[7] & ~r_ls_unsigned}}, mem_data_r[7:0]};
                w_merge    = {mem_data_r[DATA_WIDTH-1:8], r_ls_wdata[7:0]};
            end
            LS_SIZE_H: begin
                w_load_ext = {{(DATA_WIDTH-16){mem_data_r[15] & ~r_ls_unsigned}}, mem_data_r[15:0]};
                w_merge    = {mem_data_r[DATA_WIDTH-1:16], r_ls_wdata[15:0]};
            end
            LS_SIZE_W, 2'd3: begin
                w_load_ext = mem_data_r;
                w_merge    = mem_data_r;
            end
        endcase
    end

    // Mem command and completion registers; request fields are captured at accept.
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            r_mem_op      <= 1'b0;
            r_mem_rw      <= 1'b0;
            r_mem_addr    <= '0;
            r_mem_data_w  <= '0;
            r_if_rvalid   <= 1'b0;
            r_if_rdata    <= '0;
            r_ls_done     <= 1'b0;
            r_ls_rdata    <= '0;
            r_ls_size     <= LS_SIZE_B;
            r_ls_unsigned <= 1'b0;
            r_ls_wdata    <= '0;
            r_oob         <= 1'b0;
        end else begin
            r_if_rvalid <= 1'b0;
            r_ls_done   <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_gnt_if) begin
                        r_mem_op   <= 1'b1;
                        r_mem_rw   <= 1'b0;
                        r_mem_addr <= if_addr;
                    end else if (w_gnt_ls) begin
                        r_mem_op      <= !w_oob;
                        r_mem_rw      <= ls_we && !w_ls_sub && !w_oob;
                        r_mem_addr    <= ls_addr;
                        r_mem_data_w  <= ls_wdata;
                        r_ls_size     <= ls_size;
                        r_ls_unsigned <= ls_unsigned;
                        r_ls_wdata    <= ls_wdata[15:0];
                        r_oob         <= w_oob;
                    end
                end
                ST_IF_RD: begin
                    r_if_rdata  <= mem_data_r;
                    r_if_rvalid <= 1'b1;
                    r_mem_op    <= 1'b0;
                end
                ST_LS_RD: begin
                    if (!r_oob) begin
                        r_ls_rdata <= w_load_ext;
                    end
                    r_ls_done <= 1'b1;
                    r_mem_op  <= 1'b0;
                end
                ST_RMW_RD: begin
                    r_mem_rw     <= 1'b1;
                    r_mem_data_w <= w_merge;
                end
                ST_LS_WR, ST_RMW_WR: begin
                    r_ls_done <= 1'b1;
                    r_mem_op  <= 1'b0;
                    r_mem_rw  <= 1'b0;
                end
                default: begin
                    r_mem_op <= 1'b0;
                    r_mem_rw <= 1'b0;
                end
            endcase
        end
    end

    assign mem_op     = r_mem_op;
    assign mem_rw     = r_mem_rw;
    assign mem_addr   = r_mem_addr;
    assign mem_data_w = r_mem_data_w;
    assign if_rvalid  = r_if_rvalid;
    assign if_rdata   = r_if_rdata;
    assign ls_done    = r_ls_done;
    assign ls_rdata   = r_ls_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: byte-array Mem model, directed scenarios,
// then randomized traffic checked against a byte-level golden memory.
module tb_mem_arbiter;

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_ready;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        ls_req;
    logic        ls_we;
    logic [1:0]  ls_size;
    logic        ls_unsigned;
    logic [31:0] ls_addr;
    logic [31:0] ls_wdata;
    logic        ls_ready;
    logic        ls_done;
    logic [31:0] ls_rdata;
    logic        ls_err;
    logic        mem_op;
    logic        mem_rw;
    logic [31:0] mem_addr;
    logic [31:0] mem_data_w;
    logic [31:0] mem_data_r = '0;

    int checkCount = 0;
    int errorCount = 0;

    logic [7:0]  physMem [0:1023];
    logic [7:0]  refMem  [0:1023];
    logic [31:0] lastLsRdata = '0;
    logic [31:0] memRdTmp;

    mem_arbiter dut (
        .sys_clk     (sys_clk),
        .sys_rst     (sys_rst),
        .if_req      (if_req),
        .if_addr     (if_addr),
        .if_ready    (if_ready),
        .if_rvalid   (if_rvalid),
        .if_rdata    (if_rdata),
        .ls_req      (ls_req),
        .ls_we       (ls_we),
        .ls_size     (ls_size),
        .ls_unsigned (ls_unsigned),
        .ls_addr     (ls_addr),
        .ls_wdata    (ls_wdata),
        .ls_ready    (ls_ready),
        .ls_done     (ls_done),
        .ls_rdata    (ls_rdata),
        .ls_err      (ls_err),
        .mem_op      (mem_op),
        .mem_rw      (mem_rw),
        .mem_addr    (mem_addr),
        .mem_data_w  (mem_data_w),
        .mem_data_r  (mem_data_r)
    );

    always #5 sys_clk = ~sys_clk;

    // Mem: samples its command on the falling edge, little-endian, unaligned, wraps at 1 KiB.
    always @(negedge sys_clk) begin
        if (mem_op) begin
            if (mem_rw) begin
                for (int k = 0; k < 4; k++) begin
                    physMem[int'((mem_addr + 32'(k)) % 32'd1024)] = 8'(mem_data_w >> (8 * k));
                end
            end else begin
                memRdTmp = '0;
                for (int k = 0; k < 4; k++) begin
                    memRdTmp = memRdTmp | (32'(physMem[int'((mem_addr + 32'(k)) % 32'd1024)]) << (8 * k));
                end
                mem_data_r <= memRdTmp;
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    function automatic logic [31:0] refWord(input logic [31:0] addr);
        logic [31:0] w;
        w = '0;
        for (int k = 0; k < 4; k++) begin
            w = w | (32'(refMem[int'((addr + 32'(k)) % 32'd1024)]) << (8 * k));
        end
        return w;
    endfunction

    function automatic logic [31:0] refLoad(input logic [31:0] addr, input logic [1:0] size, input logic uns);
        logic [31:0] w;
        int v;
        w = refWord(addr);
        if (size == 2'd0) begin
            v = int'(w % 32'd256);
            if (!uns && v >= 128) v = v - 256;
            return 32'(v);
        end else if (size == 2'd1) begin
            v = int'(w % 32'd65536);
            if (!uns && v >= 32768) v = v - 65536;
            return 32'(v);
        end
        return w;
    endfunction

    task automatic refStore(input logic [31:0] addr, input logic [1:0] size, input logic [31:0] data);
        int n;
        n = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        for (int k = 0; k < n; k++) begin
            refMem[int'((addr + 32'(k)) % 32'd1024)] = 8'(data >> (8 * k));
        end
    endtask

    function automatic logic refOutOfRange(input logic [31:0] addr);
`ifdef MEM_ARB_BOUNDS_EN
        return addr > 32'd1020;
`else
        return (addr != addr);
`endif
    endfunction

    // One load/store transaction: predict, issue, then check timing, Mem command and data.
    task automatic applyStimulus(input logic we, input logic [1:0] size, input logic uns,
                                 input logic [31:0] addr, input logic [31:0] wdata);
        logic        oob;
        int          expLat;
        int          lat;
        int          waitCyc;
        logic [31:0] expRdata;
        oob      = refOutOfRange(addr);
        expLat   = (!oob && we && size < 2'd2) ? 2 : 1;
        expRdata = lastLsRdata;
        if (!oob) begin
            if (we) refStore(addr, size, wdata);
            else    expRdata = refLoad(addr, size, uns);
        end

        @(negedge sys_clk);
        ls_req = 1'b1; ls_we = we; ls_size = size; ls_unsigned = uns;
        ls_addr = addr; ls_wdata = wdata;
        #1;
        waitCyc = 0;
        while (!ls_ready && waitCyc < 20) begin
            @(negedge sys_clk); #1;
            waitCyc++;
        end
        checkOutput("ls_ready", 32'(ls_ready), 32'd1);
        if (!ls_ready) begin
            ls_req = 1'b0;
            return;
        end

        @(posedge sys_clk); #1;
        ls_req = 1'b0; ls_we = 1'($urandom); ls_size = 2'($urandom);
        ls_unsigned = 1'($urandom); ls_addr = $urandom; ls_wdata = $urandom;
        checkOutput("mem_op_issue", 32'(mem_op), 32'(!oob));
        if (!oob) begin
            checkOutput("mem_addr_issue", mem_addr, addr);
            checkOutput("mem_rw_issue", 32'(mem_rw), 32'(we && size >= 2'd2));
        end

        lat = 0;
        while (!ls_done && lat < 6) begin
            @(posedge sys_clk); #1;
            lat++;
        end
        checkOutput("ls_latency", 32'(lat), 32'(expLat));
        checkOutput("ls_err", 32'(ls_err), 32'(oob));
        checkOutput("ls_rdata", ls_rdata, expRdata);
        lastLsRdata = expRdata;
        @(posedge sys_clk); #1;
        checkOutput("ls_done_pulse", 32'(ls_done), 32'd0);
    endtask

    task automatic fetchWord(input logic [31:0] addr);
        int waitCyc;
        @(negedge sys_clk);
        if_req = 1'b1; if_addr = addr;
        #1;
        waitCyc = 0;
        while (!if_ready && waitCyc < 20) begin
            @(negedge sys_clk); #1;
            waitCyc++;
        end
        checkOutput("if_ready", 32'(if_ready), 32'd1);
        if (!if_ready) begin
            if_req = 1'b0;
            return;
        end
        @(posedge sys_clk); #1;
        if_req = 1'b0; if_addr = $urandom;
        @(posedge sys_clk); #1;
        checkOutput("if_rvalid", 32'(if_rvalid), 32'd1);
        checkOutput("if_rdata", if_rdata, refWord(addr));
        @(posedge sys_clk); #1;
        checkOutput("if_rvalid_pulse", 32'(if_rvalid), 32'd0);
    endtask

    initial begin
        int grants[$];
        logic [31:0] rnd;

        sys_rst = 1'b0;
        if_req = 1'b0; if_addr = '0;
        ls_req = 1'b0; ls_we = 1'b0; ls_size = 2'd0; ls_unsigned = 1'b0;
        ls_addr = '0; ls_wdata = '0;
        for (int i = 0; i < 1024; i++) begin
            rnd = $urandom;
            physMem[i] = rnd[7:0];
            refMem[i]  = rnd[7:0];
        end
        physMem[0] = 8'h13; physMem[1] = 8'h05; physMem[2] = 8'h10; physMem[3] = 8'h00;
        refMem[0]  = 8'h13; refMem[1]  = 8'h05; refMem[2]  = 8'h10; refMem[3]  = 8'h00;

        repeat (2) @(posedge sys_clk);
        #1;
        checkOutput("rst_mem_op", 32'(mem_op), 32'd0);
        checkOutput("rst_mem_rw", 32'(mem_rw), 32'd0);
        checkOutput("rst_mem_addr", mem_addr, 32'd0);
        checkOutput("rst_mem_data_w", mem_data_w, 32'd0);
        checkOutput("rst_if_rvalid", 32'(if_rvalid), 32'd0);
        checkOutput("rst_if_rdata", if_rdata, 32'd0);
        checkOutput("rst_ls_done", 32'(ls_done), 32'd0);
        checkOutput("rst_ls_rdata", ls_rdata, 32'd0);
        checkOutput("rst_ls_err", 32'(ls_err), 32'd0);

        // First fetch straight out of reset is accepted on the first edge.
        @(negedge sys_clk);
        sys_rst = 1'b1; if_req = 1'b1; if_addr = 32'h0;
        #1;
        checkOutput("first_if_ready", 32'(if_ready), 32'd1);
        @(posedge sys_clk); #1;
        if_req = 1'b0;
        checkOutput("first_if_rvalid_T", 32'(if_rvalid), 32'd0);
        @(posedge sys_clk); #1;
        checkOutput("first_if_rvalid", 32'(if_rvalid), 32'd1);
        checkOutput("first_if_rdata", if_rdata, 32'h00100513);

        applyStimulus(1'b1, 2'd2, 1'b0, 32'h40, 32'hDEADBEEF);
        applyStimulus(1'b0, 2'd0, 1'b0, 32'h41, 32'h0);
        checkOutput("lb_0x41", ls_rdata, 32'hFFFFFFBE);
        applyStimulus(1'b1, 2'd0, 1'b0, 32'h40, 32'h1234565A);
        applyStimulus(1'b0, 2'd2, 1'b0, 32'h40, 32'h0);
        checkOutput("lw_after_sb", ls_rdata, 32'hDEADBE5A);

        // Reset while the RMW read is in flight must abort without side effects.
        @(negedge sys_clk);
        ls_req = 1'b1; ls_we = 1'b1; ls_size = 2'd0; ls_unsigned = 1'b0;
        ls_addr = 32'h40; ls_wdata = 32'h00000077;
        #1;
        checkOutput("rmw_abort_ready", 32'(ls_ready), 32'd1);
        @(posedge sys_clk); #2;
        sys_rst = 1'b0; ls_req = 1'b0;
        #1;
        checkOutput("rmw_abort_mem_op", 32'(mem_op), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge sys_clk); #1;
            checkOutput("rmw_abort_no_done", 32'(ls_done), 32'd0);
        end
        @(negedge sys_clk);
        sys_rst = 1'b1;
        lastLsRdata = '0;
        applyStimulus(1'b0, 2'd2, 1'b0, 32'h40, 32'h0);
        checkOutput("lw_after_abort", ls_rdata, 32'hDEADBE5A);

        // Both ports held: grants must alternate starting with fetch after reset.
        @(negedge sys_clk); sys_rst = 1'b0;
        @(negedge sys_clk); sys_rst = 1'b1;
        if_req = 1'b1; if_addr = 32'h0;
        ls_req = 1'b1; ls_we = 1'b0; ls_size = 2'd2; ls_unsigned = 1'b0; ls_addr = 32'h40;
        #1;
        for (int i = 0; i < 16; i++) begin
            if (if_ready && ls_ready) checkOutput("rr_both_ready", 32'd1, 32'd0);
            if (if_ready) grants.push_back(0);
            else if (ls_ready) grants.push_back(1);
            @(negedge sys_clk); #1;
        end
        if_req = 1'b0; ls_req = 1'b0;
        checkOutput("rr_grant_count", 32'(grants.size()), 32'd8);
        foreach (grants[i]) checkOutput($sformatf("rr_grant_%0d", i), 32'(grants[i]), 32'(i % 2));
        repeat (2) @(posedge sys_clk);
        lastLsRdata = refLoad(32'h40, 2'd2, 1'b0);
        checkOutput("rr_ls_rdata", ls_rdata, lastLsRdata);

`ifdef MEM_ARB_BOUNDS_EN
        applyStimulus(1'b0, 2'd2, 1'b0, 32'h3FE, 32'h0);
        applyStimulus(1'b1, 2'd0, 1'b0, 32'h3FD, 32'hA5);
        applyStimulus(1'b0, 2'd2, 1'b1, 32'h3FC, 32'h0);
`endif

        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                fetchWord(32'($urandom_range(0, 1023)));
            end else begin
                rnd = ($urandom_range(0, 7) == 0) ? 32'(1016 + $urandom_range(0, 7))
                                                  : 32'(128 + $urandom_range(0, 255));
                applyStimulus(1'($urandom), 2'($urandom), 1'($urandom), rnd, $urandom);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
